uart_buffer_sequencer: RTL and testbench

UART_BUFFER_SEQUENCER -- requirements
Module: uart_buffer_sequencer

---
 rtl/uart_buffer_sequencer_pkg.sv | 25 ++
 rtl/uart_buffer_sequencer_xform.sv | 24 ++
 rtl/uart_buffer_sequencer.sv | 130 +++++++++++++
 tb/tb_uart_buffer_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_buffer_sequencer_pkg.sv
// Shared encodings for the UART buffer sequencer: FSM states and per-byte
// operation modes.
package uart_buffer_sequencer_pkg;

    localparam int BYTE_W  = 8;
    localparam int STATE_W = 3;
    localparam int MODE_W  = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_READ  = 3'd1;
    localparam logic [STATE_W-1:0] ST_WRITE = 3'd2;
    localparam logic [STATE_W-1:0] ST_KICK  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DRAIN = 3'd4;

    localparam logic [MODE_W-1:0] MODE_PASS = 2'd0;
    localparam logic [MODE_W-1:0] MODE_INV  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_ADD  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_XOR  = 2'd3;

    // Pass-through frames still walk the buffer but never write it back.
    function automatic logic mode_writes(input logic [MODE_W-1:0] m);
        return m != MODE_PASS;
    endfunction

endpackage

// File: rtl/uart_buffer_sequencer_xform.sv
// Combinational per-byte transform applied to each buffer byte on its way
// back to the handler.
module uart_byte_xform
    import uart_buffer_sequencer_pkg::*;
(
    input  logic [MODE_W-1:0] mode,
    input  logic [BYTE_W-1:0] key,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout
);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves dout unassigned (no latch).
        dout = din;
        case (mode)
            MODE_PASS: dout = din;
            MODE_INV:  dout = ~din;
            MODE_ADD:  dout = din + key;
            MODE_XOR:  dout = din ^ key;
            default:   dout = din;
        endcase
    end

endmodule

// File: rtl/uart_buffer_sequencer.sv
// Walks the handler buffer once per frame (read, transform, write back),
// accumulates a byte checksum and hands the buffer back with a start pulse.
module uart_buffer_sequencer
    import uart_buffer_sequencer_pkg::*;
#(
    parameter int RAM_SIZE  = 64,
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [7:0]           key,
    input  logic                 ready,
    input  logic [7:0]           rdata,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 writeEnable,
    output logic [7:0]           wdata,
    output logic                 start,
    output logic                 busy,
    output logic [7:0]           checksum,
    output logic [15:0]          frame_count
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(RAM_SIZE - 1);

    logic [STATE_W-1:0]   state_q, state_d;
    logic [ADDR_BITS-1:0] index_q, index_d;
    logic [BYTE_W-1:0]    sum_q, sum_d;
    logic [BYTE_W-1:0]    checksum_q, checksum_d;
    logic [15:0]          frame_count_q, frame_count_d;
    logic [MODE_W-1:0]    mode_q, mode_d;
    logic [BYTE_W-1:0]    key_q, key_d;
    logic [BYTE_W-1:0]    xbyte;

    uart_byte_xform u_xform (
        .mode (mode_q),
        .key  (key_q),
        .din  (rdata),
        .dout (xbyte)
    );

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        sum_d         = sum_q;
        checksum_d    = checksum_q;
        frame_count_d = frame_count_q;
        mode_d        = mode_q;
        key_d         = key_q;

        case (state_q)
            ST_IDLE: begin
                if (ready && enable) begin
                    state_d = ST_READ;
                    mode_d  = mode;
                    key_d   = key;
                    index_d = '0;
                    sum_d   = '0;
                end
            end
            // Losing ready mid-walk means the handler reclaimed the buffer.
            ST_READ: begin
                state_d = ready ? ST_WRITE : ST_IDLE;
            end
            ST_WRITE: begin
                if (!ready) begin
                    state_d = ST_IDLE;
                end else begin
                    sum_d = sum_q + xbyte;
                    if (index_q == LAST_IDX) begin
                        state_d = ST_KICK;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_KICK: begin
                checksum_d    = sum_q;
                frame_count_d = frame_count_q + 16'd1;
                state_d       = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (reset) begin
            state_q       <= ST_IDLE;
            index_q       <= '0;
            sum_q         <= '0;
            checksum_q    <= '0;
            frame_count_q <= '0;
            mode_q        <= MODE_PASS;
            key_q         <= '0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            sum_q         <= sum_d;
            checksum_q    <= checksum_d;
            frame_count_q <= frame_count_d;
            mode_q        <= mode_d;
            key_q         <= key_d;
        end
    end

    always_comb begin
        addr        = '0;
        wdata       = '0;
        writeEnable = 1'b0;
        if (state_q == ST_READ) begin
            addr = index_q;
        end else if (state_q == ST_WRITE) begin
            addr        = index_q;
            wdata       = xbyte;
            writeEnable = ready && mode_writes(mode_q);
        end
    end

    assign start       = (state_q == ST_KICK);
    assign busy        = (state_q != ST_IDLE);
    assign checksum    = checksum_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_uart_buffer_sequencer.sv
// Randomized bench for uart_buffer_sequencer with an emulated handler buffer
// and a frame-level reference model.
module tb_uart_buffer_sequencer;

    localparam int N  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [1:0]    mode;
    logic [7:0]    key;
    logic          ready;
    logic [7:0]    rdata;
    logic [AW-1:0] addr;
    logic          writeEnable;
    logic [7:0]    wdata;
    logic          start;
    logic          busy;
    logic [7:0]    checksum;
    logic [15:0]   frame_count;

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] load_data [0:N-1];
    logic       load_req;

    int checks = 0;
    int errors = 0;
    int fc_model = 0;
    int cs_model = 0;
    logic [7:0] cur_buf [0:N-1];

    uart_buffer_sequencer #(.RAM_SIZE(N), .ADDR_BITS(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .key         (key),
        .ready       (ready),
        .rdata       (rdata),
        .addr        (addr),
        .writeEnable (writeEnable),
        .wdata       (wdata),
        .start       (start),
        .busy        (busy),
        .checksum    (checksum),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // Handler buffer: registered read, write on strobe, bulk preload from the bench.
    always @(posedge clk) begin
        rdata <= mem[addr];
        if (load_req) begin
            for (int i = 0; i < N; i++) mem[i] <= load_data[i];
        end else if (writeEnable) begin
            mem[addr] <= wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_f(input int m, input int k, input int b);
        int r;
        case (m)
            0:       r = b;
            1:       r = 255 - b;
            2:       r = (b + k) % 256;
            default: r = b ^ k;
        endcase
        return 8'(r);
    endfunction

    task automatic load_buffer();
        for (int i = 0; i < N; i++) load_data[i] = cur_buf[i];
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic random_buffer();
        for (int i = 0; i < N; i++) cur_buf[i] = 8'($urandom_range(0, 255));
    endtask

    // One complete frame, including the drain phase with ready held high.
    task automatic run_frame(input int m, input int k);
        logic [7:0] exp_buf [0:N-1];
        int sum, edges, writes, bad_addr, extra;
        bit seen;
        load_buffer();
        sum = 0;
        for (int i = 0; i < N; i++) begin
            exp_buf[i] = (m == 0) ? cur_buf[i] : model_f(m, k, int'(cur_buf[i]));
            sum += int'(model_f(m, k, int'(cur_buf[i])));
        end
        mode = 2'(m); key = 8'(k); ready = 1'b1; enable = 1'b1;
        tick();
        check("busy_after_exit", 32'(busy), 1);
        enable = 1'b0;
        edges = 0; writes = 0; bad_addr = 0; seen = 0;
        while (edges < 40) begin
            if (start) begin
                seen = 1;
                break;
            end
            if (writeEnable) writes++;
            if (int'(addr) >= N) bad_addr++;
            mode = 2'($urandom_range(0, 3));
            key  = 8'($urandom_range(0, 255));
            tick();
            edges++;
        end
        check("start_seen", 32'(seen), 1);
        check("start_latency", edges, 2 * N);
        check("write_count", writes, (m == 0) ? 0 : N);
        check("addr_range", bad_addr, 0);
        tick();
        fc_model = (fc_model + 1) % 65536;
        cs_model = sum % 256;
        check("checksum", 32'(checksum), cs_model);
        check("frame_count", 32'(frame_count), fc_model);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (start) extra++;
            tick();
        end
        check("no_restart", extra, 0);
        check("busy_in_drain", 32'(busy), 1);
        ready = 1'b0;
        tick();
        check("idle_after_drain", 32'(busy), 0);
        for (int i = 0; i < N; i++) check($sformatf("buf[%0d]", i), 32'(mem[i]), 32'(exp_buf[i]));
    endtask

    // Starts a frame and stops with the DUT in WRITE of byte index 2.
    task automatic enter_write2(input int m, input int k);
        load_buffer();
        mode = 2'(m); key = 8'(k); ready = 1'b1; enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        int m, k;
        reset = 1'b1; ready = 1'b0; enable = 1'b0; mode = '0; key = '0; load_req = 1'b0;
        for (int i = 0; i < N; i++) cur_buf[i] = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_start", 32'(start), 0);
        check("rst_we", 32'(writeEnable), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_checksum", 32'(checksum), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        reset = 1'b0;
        tick();

        cur_buf = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_frame(1, 0);
        check("invert_checksum", 32'(checksum), 32'h0000_00F2);

        cur_buf = '{8'h00, 8'h80, 8'hFF, 8'h01};
        run_frame(2, 8'hFF);
        check("add_wrap_checksum", 32'(checksum), 32'h0000_007C);

        random_buffer();
        run_frame(0, int'($urandom_range(0, 255)));

        for (int f = 0; f < 6; f++) begin
            random_buffer();
            run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
        end

        // Handler reclaims the buffer mid-frame.
        random_buffer();
        m = int'($urandom_range(1, 3));
        k = int'($urandom_range(0, 255));
        enter_write2(m, k);
        check("pre_abort_we", 32'(writeEnable), 1);
        ready = 1'b0;
        #1;
        check("abort_we", 32'(writeEnable), 0);
        tick();
        check("abort_busy", 32'(busy), 0);
        check("abort_checksum", 32'(checksum), cs_model);
        check("abort_frame_count", 32'(frame_count), fc_model);
        check("abort_byte2_untouched", 32'(mem[2]), 32'(cur_buf[2]));
        check("abort_byte1_written", 32'(mem[1]), 32'(model_f(m, k, int'(cur_buf[1]))));

        // Reset lands mid-frame, then a frame restarts immediately after release.
        random_buffer();
        enter_write2(int'($urandom_range(1, 3)), int'($urandom_range(0, 255)));
        check("pre_reset_we", 32'(writeEnable), 1);
        reset = 1'b1;
        tick();
        fc_model = 0;
        cs_model = 0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_we", 32'(writeEnable), 0);
        check("mid_rst_addr", 32'(addr), 0);
        check("mid_rst_wdata", 32'(wdata), 0);
        check("mid_rst_start", 32'(start), 0);
        check("mid_rst_frame_count", 32'(frame_count), 0);
        check("mid_rst_checksum", 32'(checksum), 0);
        enable = 1'b1;
        reset = 1'b0;
        tick();
        check("restart_after_reset", 32'(busy), 1);
        ready = 1'b0;
        enable = 1'b0;
        tick();
        check("restart_abort_idle", 32'(busy), 0);

        random_buffer();
        run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
